myproject_sdiv_21s_9ns_12_seq: RTL

- Sequential signed-by-unsigned integer divider. It is the inverse of the 12s x 9ns -> 21 multiplier used in the datapath.
- Divides a 21-bit signed dividend by a 9-bit unsigned divisor and returns a saturated 12-bit signed quotient and a signed remainder.
- Used after accumulation for rescaling and normalisation of layer outputs.
- Radix-2 restoring algorithm on magnitudes, one quotient bit per cycle, with an ap_start/ap_done block-level handshake.

---
 rtl/myproject_sdiv_21s_9ns_12_seq.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/myproject_sdiv_21s_9ns_12_seq.sv
// Sequential signed-by-unsigned divider: restoring radix-2 on magnitudes, one quotient bit per cycle,
// saturated signed quotient and dividend-signed remainder, ap_start/ap_done handshake.
module myproject_sdiv_21s_9ns_12_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 21,
    parameter int din1_WIDTH = 9,
    parameter int dout_WIDTH = 12,
    parameter int rem_WIDTH  = 10
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    output logic                  ap_ready,
    output logic                  ap_idle,
    output logic                  ap_done,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout,
    output logic [rem_WIDTH-1:0]  rem,
    output logic                  ovf,
    output logic                  dz
);

    if (rem_WIDTH != din1_WIDTH + 1 || ID < 0) begin : g_bad_cfg
        $error("myproject_sdiv_21s_9ns_12_seq: rem_WIDTH must equal din1_WIDTH+1");
    end

    localparam int CW = $clog2(din0_WIDTH);
    localparam logic [CW-1:0]         LAST     = CW'(din0_WIDTH - 1);
    localparam logic [dout_WIDTH-1:0] QMAX     = {1'b0, {(dout_WIDTH-1){1'b1}}};
    localparam logic [dout_WIDTH-1:0] QMIN     = {1'b1, {(dout_WIDTH-1){1'b0}}};
    localparam logic [din0_WIDTH-1:0] QPOS_LIM = din0_WIDTH'((64'd1 << (dout_WIDTH-1)) - 64'd1);
    localparam logic [din0_WIDTH-1:0] QNEG_LIM = din0_WIDTH'(64'd1 << (dout_WIDTH-1));

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [din0_WIDTH-1:0] acc;     // dividend magnitude shifts out MSB-first, quotient bits shift in
    logic [din1_WIDTH:0]   part;
    logic [din1_WIDTH-1:0] dvsr;
    logic                  sign;

    logic [din0_WIDTH-1:0] mag;
    logic [din1_WIDTH:0]   trial;
    logic [din1_WIDTH:0]   part_nxt;
    logic [din0_WIDTH-1:0] acc_nxt;
    logic                  qbit;
    logic [dout_WIDTH-1:0] q_sat;
    logic                  q_ovf;
    logic [rem_WIDTH-1:0]  r_fin;

    assign ap_ready = ap_start & (state == IDLE);

    always_comb begin
        mag      = din0[din0_WIDTH-1] ? (~din0 + 1'b1) : din0;
        trial    = {part[din1_WIDTH-1:0], acc[din0_WIDTH-1]};
        qbit     = (trial >= {1'b0, dvsr});
        part_nxt = qbit ? (trial - {1'b0, dvsr}) : trial;
        acc_nxt  = {acc[din0_WIDTH-2:0], qbit};
        q_ovf    = 1'b0;
        q_sat    = acc_nxt[dout_WIDTH-1:0];
        if (sign) begin
            if (acc_nxt > QNEG_LIM) begin
                q_ovf = 1'b1;
                q_sat = QMIN;
            end else begin
                q_sat = -acc_nxt[dout_WIDTH-1:0];
            end
        end else if (acc_nxt > QPOS_LIM) begin
            q_ovf = 1'b1;
            q_sat = QMAX;
        end
        r_fin = sign ? (~part_nxt + 1'b1) : part_nxt;
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state   <= IDLE;
            ap_idle <= 1'b1;
            ap_done <= 1'b0;
            dout    <= '0;
            rem     <= '0;
            ovf     <= 1'b0;
            dz      <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            part    <= '0;
            dvsr    <= '0;
            sign    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        ap_idle <= 1'b0;
                        if (din1 == '0) begin
                            state   <= DONE;
                            ap_done <= 1'b1;
                            dz      <= 1'b1;
                            ovf     <= 1'b0;
                            rem     <= '0;
                            dout    <= din0[din0_WIDTH-1] ? QMIN : QMAX;
                        end else begin
                            state <= CALC;
                            acc   <= mag;
                            part  <= '0;
                            dvsr  <= din1;
                            sign  <= din0[din0_WIDTH-1];
                            cnt   <= '0;
                        end
                    end
                end
                CALC: begin
                    acc  <= acc_nxt;
                    part <= part_nxt;
                    cnt  <= cnt + 1'b1;
                    // results are formed from the final iteration's combinational values
                    if (cnt == LAST) begin
                        state   <= DONE;
                        ap_done <= 1'b1;
                        dout    <= q_sat;
                        rem     <= r_fin;
                        ovf     <= q_ovf;
                        dz      <= 1'b0;
                        cnt     <= '0;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    ap_done <= 1'b0;
                    ap_idle <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ap_done <= 1'b0;
                    ap_idle <= 1'b1;
                end
            endcase
        end
    end

endmodule
